// File: rtl/banked_dual_port_memory_pkg.sv
// Shared types and address helpers for the banked dual-port scratch memory.
// Banks are low-order interleaved: consecutive words land in consecutive banks.
package banked_mem_pkg;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_ELEM_W     = 8;
  localparam int DEF_NUM_BANKS  = 4;
  localparam int DEF_BANK_DEPTH = 64;
  localparam int DEF_ADDR_W     = $clog2(DEF_NUM_BANKS * DEF_BANK_DEPTH);
  localparam int DEF_MASK_W     = DEF_WIDTH / DEF_ELEM_W;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_MASK_W-1:0] wmask;
    logic [DEF_WIDTH-1:0]  wdata;
  } mem_req_t;

  function automatic int bank_of(input int addr, input int num_banks);
    return addr % num_banks;
  endfunction

  function automatic int row_of(input int addr, input int num_banks);
    return addr / num_banks;
  endfunction

endpackage

// File: rtl/banked_dual_port_memory_if.sv
// One request/response port of the banked memory: req/ready handshake plus
// a registered read response.
interface banked_dual_port_memory_if #(
  parameter int WIDTH      = 16,
  parameter int ELEM_W     = 8,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_DEPTH = 64
);
  localparam int ADDR_W = $clog2(NUM_BANKS * BANK_DEPTH);
  localparam int MASK_W = WIDTH / ELEM_W;

  logic              req;
  logic              ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [MASK_W-1:0] wmask;
  logic [WIDTH-1:0]  wdata;
  logic              rvalid;
  logic [WIDTH-1:0]  rdata;

  modport master (
    output req, we, addr, wmask, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wmask, wdata,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/banked_dual_port_memory_bank.sv
// Single-port memory bank: synchronous read into an output register and an
// element-masked write. Storage and read register carry no reset.
module mem_bank #(
  parameter int  WIDTH                = 16,
  parameter int  ELEM_W               = 8,
  parameter int  BANK_DEPTH           = 64,
  parameter int  USED_AS_EXTERNAL_MEM = 0,
  localparam int MASK_W               = WIDTH / ELEM_W,
  localparam int ROW_W                = $clog2(BANK_DEPTH)
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ROW_W-1:0]  i_row,
  input  logic [MASK_W-1:0] i_wmask,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [BANK_DEPTH];
  logic [WIDTH-1:0] r_rdata_p1;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int e = 0; e < MASK_W; e++) begin
          if (i_wmask[e]) begin
            r_mem[i_row][e*ELEM_W +: ELEM_W] <= i_wdata[e*ELEM_W +: ELEM_W];
          end
        end
      end else begin
        r_rdata_p1 <= r_mem[i_row];
      end
    end
  end

  assign o_rdata = r_rdata_p1;

`ifndef TARGET_SYNTHESIS
  // Model-only accounting: macro area per bank and energy per accepted access.
  localparam longint AREA = (USED_AS_EXTERNAL_MEM != 0) ? 64'd0 :
                            (BANK_DEPTH < 128) ? longint'(17 * WIDTH * BANK_DEPTH)
                                               : longint'(WIDTH * BANK_DEPTH);
  localparam real E_PER_ACCESS = WIDTH * ((USED_AS_EXTERNAL_MEM != 0) ? 1.0 : 0.1);

  logic [63:0] area_units;
  real         r_energy;

  assign area_units = 64'(AREA);

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_energy <= r_energy + E_PER_ACCESS;
    end
  end
`endif

endmodule

// File: rtl/banked_dual_port_memory.sv
// Two-port, address-interleaved scratch memory: round-robin arbitration on
// same-bank collisions, bank select mux and a 1-cycle read response per port.
module banked_dual_port_memory
  import banked_mem_pkg::*;
#(
  parameter int WIDTH                = 16,
  parameter int ELEM_W               = 8,
  parameter int NUM_BANKS            = 4,
  parameter int BANK_DEPTH           = 64,
  parameter int USED_AS_EXTERNAL_MEM = 0
) (
  input  logic                       clk,
  input  logic                       arst_n_in,
  banked_dual_port_memory_if.slave   a,
  banked_dual_port_memory_if.slave   b
);

  localparam int ADDR_W = $clog2(NUM_BANKS * BANK_DEPTH);
  localparam int MASK_W = WIDTH / ELEM_W;
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ROW_W  = $clog2(BANK_DEPTH);

  if (NUM_BANKS < 2 || (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_chk_banks
    $error("NUM_BANKS must be a power of two and at least 2");
  end
  if ((WIDTH % ELEM_W) != 0) begin : g_chk_mask
    $error("WIDTH must be a multiple of ELEM_W");
  end

  logic [BANK_W-1:0] w_a_bank, w_b_bank;
  logic [ROW_W-1:0]  w_a_row,  w_b_row;

  assign w_a_bank = BANK_W'(bank_of(int'(a.addr), NUM_BANKS));
  assign w_b_bank = BANK_W'(bank_of(int'(b.addr), NUM_BANKS));
  assign w_a_row  = ROW_W'(row_of(int'(a.addr), NUM_BANKS));
  assign w_b_row  = ROW_W'(row_of(int'(b.addr), NUM_BANKS));

  // Arbiter: pointer holds the port that wins the next collision.
  port_e r_ptr, w_ptr_nxt;
  logic  w_conflict, w_a_grant, w_b_grant;

  always_comb begin
    w_conflict = a.req && b.req && (w_a_bank == w_b_bank);
    w_a_grant  = arst_n_in && a.req && (!w_conflict || r_ptr == PORT_A);
    w_b_grant  = arst_n_in && b.req && (!w_conflict || r_ptr == PORT_B);
    w_ptr_nxt  = r_ptr;
    if (w_conflict) begin
      w_ptr_nxt = (r_ptr == PORT_A) ? PORT_B : PORT_A;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_ptr <= PORT_A;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

  assign a.ready = w_a_grant;
  assign b.ready = w_b_grant;

  logic [WIDTH-1:0] w_bank_rdata [NUM_BANKS];

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic              w_sel_a, w_sel_b, w_en, w_we;
    logic [ROW_W-1:0]  w_row;
    logic [MASK_W-1:0] w_wmask;
    logic [WIDTH-1:0]  w_wdata;

    always_comb begin
      w_sel_a = w_a_grant && (w_a_bank == BANK_W'(g));
      w_sel_b = w_b_grant && (w_b_bank == BANK_W'(g));
      w_en    = w_sel_a || w_sel_b;
      w_we    = w_sel_a ? a.we    : b.we;
      w_row   = w_sel_a ? w_a_row : w_b_row;
      w_wmask = w_sel_a ? a.wmask : b.wmask;
      w_wdata = w_sel_a ? a.wdata : b.wdata;
    end

    mem_bank #(
      .WIDTH                (WIDTH),
      .ELEM_W               (ELEM_W),
      .BANK_DEPTH           (BANK_DEPTH),
      .USED_AS_EXTERNAL_MEM (USED_AS_EXTERNAL_MEM)
    ) u_bank (
      .clk     (clk),
      .i_en    (w_en),
      .i_we    (w_we),
      .i_row   (w_row),
      .i_wmask (w_wmask),
      .i_wdata (w_wdata),
      .o_rdata (w_bank_rdata[g])
    );
  end

  // Response stage p1: read valid plus the bank that owns the data.
  // Stage p2 keeps the last delivered word so rdata holds between responses.
  logic              r_a_rvalid_p1, r_b_rvalid_p1;
  logic [BANK_W-1:0] r_a_bank_p1,   r_b_bank_p1;
  logic [WIDTH-1:0]  r_a_rdata_p2,  r_b_rdata_p2;
  logic [WIDTH-1:0]  w_a_rdata_mux, w_b_rdata_mux;

  assign w_a_rdata_mux = w_bank_rdata[r_a_bank_p1];
  assign w_b_rdata_mux = w_bank_rdata[r_b_bank_p1];

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_a_rvalid_p1 <= 1'b0;
      r_b_rvalid_p1 <= 1'b0;
      r_a_bank_p1   <= '0;
      r_b_bank_p1   <= '0;
      r_a_rdata_p2  <= '0;
      r_b_rdata_p2  <= '0;
    end else begin
      r_a_rvalid_p1 <= w_a_grant && !a.we;
      r_b_rvalid_p1 <= w_b_grant && !b.we;
      if (w_a_grant && !a.we) r_a_bank_p1 <= w_a_bank;
      if (w_b_grant && !b.we) r_b_bank_p1 <= w_b_bank;
      if (r_a_rvalid_p1) r_a_rdata_p2 <= w_a_rdata_mux;
      if (r_b_rvalid_p1) r_b_rdata_p2 <= w_b_rdata_mux;
    end
  end

  assign a.rvalid = r_a_rvalid_p1;
  assign b.rvalid = r_b_rvalid_p1;
  assign a.rdata  = r_a_rvalid_p1 ? w_a_rdata_mux : r_a_rdata_p2;
  assign b.rdata  = r_b_rvalid_p1 ? w_b_rdata_mux : r_b_rdata_p2;

endmodule

// File: tb/tb_banked_dual_port_memory.sv
// Directed bench: stimulus pushes expected read data into per-port queues and
// a negedge monitor pops and compares every response.
module tb_banked_dual_port_memory;
  import banked_mem_pkg::*;

  localparam int WIDTH      = 16;
  localparam int ELEM_W     = 8;
  localparam int NUM_BANKS  = 4;
  localparam int BANK_DEPTH = 64;

  logic clk = 1'b0;
  logic arst_n_in;

  always #5 clk = ~clk;

  banked_dual_port_memory_if #(.WIDTH(WIDTH), .ELEM_W(ELEM_W), .NUM_BANKS(NUM_BANKS),
                               .BANK_DEPTH(BANK_DEPTH)) a_if ();
  banked_dual_port_memory_if #(.WIDTH(WIDTH), .ELEM_W(ELEM_W), .NUM_BANKS(NUM_BANKS),
                               .BANK_DEPTH(BANK_DEPTH)) b_if ();

  banked_dual_port_memory #(
    .WIDTH(WIDTH), .ELEM_W(ELEM_W), .NUM_BANKS(NUM_BANKS),
    .BANK_DEPTH(BANK_DEPTH), .USED_AS_EXTERNAL_MEM(0)
  ) u_dut (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .a         (a_if),
    .b         (b_if)
  );

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        q_a[$], q_b[$];
  int          n_checks = 0, n_pass = 0, n_acc = 0, cyc = 0;
  logic [15:0] last_a = '0, last_b = '0;
  localparam mem_req_t NOP = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic mem_req_t rd(input int addr);
    mem_req_t r = '0;
    r.addr = 8'(addr);
    return r;
  endfunction

  function automatic mem_req_t wr(input int addr, input logic [15:0] d, input logic [1:0] m);
    mem_req_t r;
    r.we = 1'b1; r.addr = 8'(addr); r.wmask = m; r.wdata = d;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  task automatic mon(input bit is_b);
    string       p   = is_b ? "b" : "a";
    logic        rv  = is_b ? b_if.rvalid : a_if.rvalid;
    logic [15:0] rdv = is_b ? b_if.rdata  : a_if.rdata;
    int          qs  = is_b ? q_b.size()  : q_a.size();
    logic [15:0] lst = is_b ? last_b      : last_a;
    exp_t        e;
    if (!arst_n_in) begin
      check({p, "_rvalid_in_reset"}, rv, 0);
      check({p, "_rdata_in_reset"}, rdv, 0);
      lst = '0;
    end else if (rv) begin
      if (qs == 0) begin
        check({p, "_unexpected_rvalid"}, rv, 0);
      end else begin
        e = is_b ? q_b.pop_front() : q_a.pop_front();
        check({p, "_rvalid_cycle"}, cyc, e.due);
        check({p, "_rdata"}, rdv, e.data);
        lst = e.data;
      end
    end else begin
      if (qs != 0) begin
        e = is_b ? q_b[0] : q_a[0];
        if (e.due <= cyc) begin
          check({p, "_missing_rvalid"}, rv, 1);
          if (is_b) void'(q_b.pop_front()); else void'(q_a.pop_front());
        end
      end
      check({p, "_rdata_hold"}, rdv, lst);
    end
    if (is_b) last_b = lst; else last_a = lst;
  endtask

  always @(negedge clk) begin
    mon(1'b0);
    mon(1'b1);
  end

  task automatic drive(input logic ar, input mem_req_t ad, input logic [15:0] aexp,
                       input logic br, input mem_req_t bd, input logic [15:0] bexp,
                       input logic era, input logic erb, input string tag);
    exp_t e;
    a_if.req = ar; a_if.we = ad.we; a_if.addr = ad.addr; a_if.wmask = ad.wmask; a_if.wdata = ad.wdata;
    b_if.req = br; b_if.we = bd.we; b_if.addr = bd.addr; b_if.wmask = bd.wmask; b_if.wdata = bd.wdata;
    @(negedge clk);
    check({tag, "_a_ready"}, a_if.ready, era);
    check({tag, "_b_ready"}, b_if.ready, erb);
    if (ar && a_if.ready) begin
      if (arst_n_in) n_acc++;
      if (!ad.we) begin e.data = aexp; e.due = cyc + 1; q_a.push_back(e); end
    end
    if (br && b_if.ready) begin
      if (arst_n_in) n_acc++;
      if (!bd.we) begin e.data = bexp; e.due = cyc + 1; q_b.push_back(e); end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    real energy;
    arst_n_in = 1'b0;
    a_if.req = 0; a_if.we = 0; a_if.addr = '0; a_if.wmask = '0; a_if.wdata = '0;
    b_if.req = 0; b_if.we = 0; b_if.addr = '0; b_if.wmask = '0; b_if.wdata = '0;

    // Reset held with arbitrary traffic: nothing may be accepted or returned.
    for (int i = 0; i < 4; i++)
      drive(1'($urandom_range(0, 1)), wr(i * 3, 16'($urandom), 2'b11), 0,
            1'($urandom_range(0, 1)), rd(i), 0, 0, 0, "reset_hold");
    arst_n_in = 1'b1;

    drive(1, wr(5, 16'h1234, 2'b11), 0, 0, NOP, 0, 1, 0, "wr5");
    drive(1, rd(5), 16'h1234, 0, NOP, 0, 1, 0, "rd5");
    drive(1, wr(9, 16'hAAAA, 2'b11), 0, 0, NOP, 0, 1, 0, "wr9_full");
    drive(1, wr(9, 16'h5555, 2'b01), 0, 0, NOP, 0, 1, 0, "wr9_mask");
    drive(1, rd(9), 16'hAA55, 0, NOP, 0, 1, 0, "rd9_mask");
    drive(1, wr(0, 16'h0F0F, 2'b11), 0, 0, NOP, 0, 1, 0, "wr0");
    drive(1, rd(0), 16'h0F0F, 1, wr(1, 16'hB1B1, 2'b11), 0, 1, 1, "noconf");
    drive(0, NOP, 0, 1, rd(1), 16'hB1B1, 0, 1, "rd1_b");
    drive(1, wr(2, 16'h2222, 2'b11), 0, 0, NOP, 0, 1, 0, "wr2");
    drive(0, NOP, 0, 1, wr(6, 16'h6666, 2'b11), 0, 0, 1, "wr6_b");

    // Same bank every cycle: grants must alternate starting with A.
    drive(1, rd(2), 16'h2222, 1, rd(6), 16'h6666, 1, 0, "rr0");
    drive(1, rd(2), 16'h2222, 1, rd(6), 16'h6666, 0, 1, "rr1");
    drive(1, rd(2), 16'h2222, 1, rd(6), 16'h6666, 1, 0, "rr2");
    drive(1, rd(2), 16'h2222, 1, rd(6), 16'h6666, 0, 1, "rr3");

    drive(0, NOP, 0, 1, wr(7, 16'hBEEF, 2'b11), 0, 0, 1, "wr7_b");
    drive(1, rd(7), 16'hBEEF, 0, NOP, 0, 1, 0, "rd7_after_wr");
    drive(1, rd(7), 16'hBEEF, 1, wr(7, 16'hCAFE, 2'b11), 0, 1, 0, "same_addr");
    drive(0, NOP, 0, 1, wr(7, 16'hCAFE, 2'b11), 0, 0, 1, "same_addr_b");
    drive(1, rd(7), 16'hCAFE, 0, NOP, 0, 1, 0, "rd7_cafe");

    drive(1, wr(255, 16'h1357, 2'b11), 0, 0, NOP, 0, 1, 0, "wr_top");
    drive(0, NOP, 0, 1, rd(255), 16'h1357, 0, 1, "rd_top");
    drive(1, wr(255, 16'hFFFF, 2'b00), 0, 0, NOP, 0, 1, 0, "wr_nomask");
    drive(0, NOP, 0, 1, rd(255), 16'h1357, 0, 1, "rd_nomask");

    drive(1, rd(5), 16'h1234, 0, NOP, 0, 1, 0, "b2b0");
    drive(1, rd(9), 16'hAA55, 0, NOP, 0, 1, 0, "b2b1");
    drive(1, rd(0), 16'h0F0F, 0, NOP, 0, 1, 0, "b2b2");

    // Reset right after a read is accepted: its response is dropped.
    drive(1, rd(5), 16'h1234, 0, NOP, 0, 1, 0, "rst_mid");
    arst_n_in = 1'b0;
    q_a.delete();
    q_b.delete();
    drive(1, rd(5), 0, 1, rd(0), 0, 0, 0, "rst_mid_hold0");
    drive(0, NOP, 0, 0, NOP, 0, 0, 0, "rst_mid_hold1");
    arst_n_in = 1'b1;
    drive(1, rd(5), 16'h1234, 1, rd(0), 16'h0F0F, 1, 1, "post_rst");

    for (int i = 0; i < 3; i++) drive(0, NOP, 0, 0, NOP, 0, 0, 0, "drain");

    check("a_queue_empty", q_a.size(), 0);
    check("b_queue_empty", q_b.size(), 0);
    check("area_total", 32'(u_dut.g_bank[0].u_bank.area_units + u_dut.g_bank[1].u_bank.area_units +
                            u_dut.g_bank[2].u_bank.area_units + u_dut.g_bank[3].u_bank.area_units),
          32'd69632);
    energy = u_dut.g_bank[0].u_bank.r_energy + u_dut.g_bank[1].u_bank.r_energy +
             u_dut.g_bank[2].u_bank.r_energy + u_dut.g_bank[3].u_bank.r_energy;
    check("energy_x10", 32'($rtoi(energy * 10.0 + 0.5)), 32'(n_acc * 16));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
